// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one BRAM port between two requesters (port 0: CPU data path,
// port 1: debug memory reader). At most one request is granted per cycle,
// the winner drives the BRAM port, and a tag pipeline routes read data back
// to the issuing port READ_LATENCY cycles after the grant.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : on contention the port that was not granted last wins.
//   undefined : fixed priority, port 0 always wins contention.
//
// Handshake: mX_req (with we/addr/wdata) is held stable until mX_gnt is seen
// high in the same cycle. The access completes in that gnt cycle. Dropping an
// ungranted req withdraws it with no side effect. mX_rvalid is a one-cycle
// pulse with no backpressure, and mX_rdata is meaningful only while it is high.
module bram_port_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic                m0_req,
   input  logic [DATA_W/8-1:0] m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   output logic                m0_gnt,
   output logic                m0_rvalid,
   output logic [DATA_W-1:0]   m0_rdata,
   input  logic                m1_req,
   input  logic [DATA_W/8-1:0] m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   output logic                m1_gnt,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                bram_en,
   output logic [DATA_W/8-1:0] bram_we,
   output logic [ADDR_W-1:0]   bram_addr,
   output logic [DATA_W-1:0]   bram_din,
   input  logic [DATA_W-1:0]   bram_dout
);

   localparam int L = READ_LATENCY;

   // id of the most recently granted port (1 = port 1)
   logic         last_q, last_d;
   // read tag pipeline: stage i holds {valid, id} of the read granted i+1 cycles ago
   logic [L-1:0] tag_v_q, tag_v_d;
   logic [L-1:0] tag_id_q, tag_id_d;

   // Grant selection, combinational on the current requests and gated by reset
   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      if (RSTN) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (m0_req && m1_req) begin
            m0_gnt = last_q;
            m1_gnt = ~last_q;
         end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
         end
`else
         m0_gnt = m0_req;
         m1_gnt = m1_req & ~m0_req;
`endif
      end
   end

   // BRAM port mux: winner drives the port, idle keeps port 0 addr/data with no write
   always_comb begin
      bram_en   = m0_gnt | m1_gnt;
      bram_we   = '0;
      bram_addr = m0_addr;
      bram_din  = m0_wdata;
      if (m1_gnt) begin
         bram_we   = m1_we;
         bram_addr = m1_addr;
         bram_din  = m1_wdata;
      end else if (m0_gnt) begin
         bram_we   = m0_we;
      end
   end

   // Next state: remember the winner and shift a read tag into the pipeline
   always_comb begin
      last_d      = last_q;
      tag_v_d     = '0;
      tag_id_d    = '0;
      if (m0_gnt || m1_gnt) begin
         last_d = m1_gnt;
      end
      tag_v_d[0]  = bram_en & (bram_we == '0);
      tag_id_d[0] = m1_gnt;
      for (int i = 1; i < L; i++) begin
         tag_v_d[i]  = tag_v_q[i-1];
         tag_id_d[i] = tag_id_q[i-1];
      end
   end

   // State registers; reset drops every in-flight read tag
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         last_q   <= 1'b0;
         tag_v_q  <= '0;
         tag_id_q <= '0;
      end else begin
         last_q   <= last_d;
         tag_v_q  <= tag_v_d;
         tag_id_q <= tag_id_d;
      end
   end

   // Return path: the last tag stage steers rvalid, data is shared by both ports
   always_comb begin
      m0_rvalid = RSTN & tag_v_q[L-1] & ~tag_id_q[L-1];
      m1_rvalid = RSTN & tag_v_q[L-1] &  tag_id_q[L-1];
      m0_rdata  = bram_dout;
      m1_rdata  = bram_dout;
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
// Bench for bram_port_arbiter with READ_LATENCY=2 and a behavioural BRAM.
// The reference model predicts the winner from the request rules, keeps its
// own memory image, and schedules each expected read return in a queue keyed
// by the cycle it is due.
`timescale 1ns/1ps
module tb_bram_port_arbiter;

   localparam int RL  = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int WBW = DW/8;
   localparam int EW  = 1 + 32 + DW;

   // ---------------- clock / reset ----------------
   logic CLK  = 1'b0;
   logic RSTN = 1'b0;
   always #5 CLK = ~CLK;

   logic           m0_req = 1'b0, m1_req = 1'b0;
   logic [WBW-1:0] m0_we = '0, m1_we = '0;
   logic [AW-1:0]  m0_addr = '0, m1_addr = '0;
   logic [DW-1:0]  m0_wdata = '0, m1_wdata = '0;
   logic           m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0]  m0_rdata, m1_rdata;
   logic           bram_en;
   logic [WBW-1:0] bram_we;
   logic [AW-1:0]  bram_addr;
   logic [DW-1:0]  bram_din, bram_dout;

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned cyc   = 0;

   bram_port_arbiter #(.READ_LATENCY(RL), .ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_din(bram_din), .bram_dout(bram_dout)
   );

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_word(input int a);
      logic [31:0] aa;
      aa = a;
      return (aa * 32'h9E37_79B1) ^ 32'h5A5A_C3A5;
   endfunction

   // ---------------- behavioural BRAM (1024 words, latency RL) ----------------
   logic [DW-1:0] mem     [0:1023];
   logic [DW-1:0] rd_pipe [0:RL-1];
   bit            mem_init = 1'b0;

   always @(posedge CLK) begin
      logic [DW-1:0] w;
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (bram_en) begin
         if (bram_we == '0) begin
            rd_pipe[0] <= mem[bram_addr[9:0]];
         end else begin
            w = mem[bram_addr[9:0]];
            for (int b = 0; b < WBW; b++)
               if (bram_we[b]) w[8*b +: 8] = bram_din[8*b +: 8];
            mem[bram_addr[9:0]] <= w;
         end
      end
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bram_dout = rd_pipe[RL-1];

   // ---------------- scoreboard / reference model ----------------
   logic [DW-1:0] ref_mem [0:1023];
   bit            ref_init = 1'b0;
   logic          last_m   = 1'b0;
   logic [EW-1:0] exp_q[$];

   always @(negedge CLK) begin
      logic           win, any, g0, g1, e0, e1;
      logic [EW-1:0]  e;
      logic [DW-1:0]  ed, wd;
      logic [WBW-1:0] wwe;
      logic [AW-1:0]  wad;
      logic [31:0]    due;
      if (!ref_init) begin
         for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
         ref_init = 1'b1;
      end
      if (!RSTN) begin
         n_cmp++;
         if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 ||
             bram_en !== 1'b0 || bram_we !== '0) begin
            n_err++;
            $display("FAIL sb_reset_outputs: gnt=%b%b rvalid=%b%b en=%b we=%h required all 0",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_en, bram_we);
         end
         exp_q.delete();
         last_m = 1'b0;
      end else begin
         any = m0_req | m1_req;
         if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = ~last_m;
`else
            win = 1'b0;
`endif
         end else begin
            win = m1_req;
         end
         g0 = any & ~win;
         g1 = any & win;
         n_cmp++;
         if (m0_gnt !== g0 || m1_gnt !== g1) begin
            n_err++;
            $display("FAIL sb_grant @%0d: got gnt0=%b gnt1=%b required gnt0=%b gnt1=%b",
                     cyc, m0_gnt, m1_gnt, g0, g1);
         end
         wwe = win ? m1_we    : m0_we;
         wad = win ? m1_addr  : m0_addr;
         wd  = win ? m1_wdata : m0_wdata;
         n_cmp++;
         if (any) begin
            if (bram_en !== 1'b1 || bram_we !== wwe || bram_addr !== wad ||
                (wwe != '0 && bram_din !== wd)) begin
               n_err++;
               $display("FAIL sb_bram_port @%0d: got en=%b we=%h addr=%h din=%h required en=1 we=%h addr=%h din=%h",
                        cyc, bram_en, bram_we, bram_addr, bram_din, wwe, wad, wd);
            end
         end else if (bram_en !== 1'b0 || bram_we !== '0) begin
            n_err++;
            $display("FAIL sb_bram_idle @%0d: got en=%b we=%h required en=0 we=0", cyc, bram_en, bram_we);
         end
         e0 = 1'b0; e1 = 1'b0; ed = '0;
         if (exp_q.size() > 0 && exp_q[0][DW +: 32] == cyc) begin
            e  = exp_q.pop_front();
            e1 = e[EW-1];
            e0 = ~e[EW-1];
            ed = e[DW-1:0];
         end
         n_cmp++;
         if (m0_rvalid !== e0 || m1_rvalid !== e1 ||
             (e0 && m0_rdata !== ed) || (e1 && m1_rdata !== ed)) begin
            n_err++;
            $display("FAIL sb_return @%0d: got rvalid=%b%b rdata0=%h rdata1=%h required rvalid=%b%b data=%h",
                     cyc, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, e0, e1, ed);
         end
         if (any) begin
            if (wwe != '0) begin
               for (int b = 0; b < WBW; b++)
                  if (wwe[b]) ref_mem[wad[9:0]][8*b +: 8] = wd[8*b +: 8];
            end else begin
               due = cyc + RL;
               exp_q.push_back({win, due, ref_mem[wad[9:0]]});
            end
            last_m = win;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge CLK); #1;
   endtask

   task automatic sample();
      @(negedge CLK); #1;
   endtask

   task automatic set_m0(input logic r, input logic [WBW-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
   endtask

   task automatic set_m1(input logic r, input logic [WBW-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         set_m0(1'b0, '0, '0, '0);
         set_m1(1'b0, '0, '0, '0);
         sample();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RSTN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         set_m0(1'b1, '0, i, '0);
         set_m1(1'b1, 4'hF, i, 32'h1);
         sample();
         n_cmp++;
         if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            n_err++; $display("FAIL reset_gnt: got %b%b required 00", m0_gnt, m1_gnt);
         end
         n_cmp++;
         if (bram_en !== 1'b0 || bram_we !== '0) begin
            n_err++; $display("FAIL reset_bram: got en=%b we=%h required 0", bram_en, bram_we);
         end
         n_cmp++;
         if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_rvalid: got %b%b required 00", m0_rvalid, m1_rvalid);
         end
      end
      next_cycle();
      RSTN = 1'b1;
      set_m0(1'b0, '0, '0, '0);
      set_m1(1'b0, '0, '0, '0);
      sample();
   endtask

   task automatic test_write_then_read();
      next_cycle();
      set_m1(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      sample();
      n_cmp++;
      if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL wtr_write_gnt: got %b required 1", m1_gnt); end
      next_cycle();
      set_m1(1'b1, 4'h0, 32'h10, 32'h0);
      sample();
      n_cmp++;
      if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL wtr_read_gnt: got %b required 1", m1_gnt); end
      for (int c = 1; c <= RL; c++) begin
         next_cycle();
         set_m1(1'b0, '0, '0, '0);
         sample();
         n_cmp++;
         if (m0_rvalid !== 1'b0) begin n_err++; $display("FAIL wtr_m0_rvalid: got %b required 0", m0_rvalid); end
         n_cmp++;
         if (c == RL) begin
            if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin
               n_err++; $display("FAIL wtr_data: got rvalid=%b rdata=%h required 1 deadbeef", m1_rvalid, m1_rdata);
            end
         end else if (m1_rvalid !== 1'b0) begin
            n_err++; $display("FAIL wtr_early_rvalid: got %b required 0", m1_rvalid);
         end
      end
      idle(RL + 1);
   endtask

   task automatic test_contention();
      int   i0, i1;
      logic ord[$];
      logic exp_ord[$];
      i0 = 0; i1 = 0;
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 8; k++) exp_ord.push_back(k % 2 == 0);
`else
      for (int k = 0; k < 8; k++) exp_ord.push_back(k >= 4);
`endif
      next_cycle();
      RSTN = 1'b0;
      sample();
      for (int c = 0; c < 20 && (i0 < 4 || i1 < 4); c++) begin
         next_cycle();
         RSTN = 1'b1;
         set_m0(i0 < 4, '0, i0, '0);
         set_m1(i1 < 4, '0, 32'h100 + i1, '0);
         sample();
         if (m0_gnt) begin ord.push_back(1'b0); i0++; end
         if (m1_gnt) begin ord.push_back(1'b1); i1++; end
      end
      n_cmp++;
      if (ord.size() != 8) begin
         n_err++; $display("FAIL contention_count: got %0d grants required 8", ord.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (ord[k] !== exp_ord[k]) begin
               n_err++; $display("FAIL contention_order[%0d]: got port %0d required port %0d", k, ord[k], exp_ord[k]);
            end
         end
      end
      idle(RL + 1);
   endtask

   task automatic test_pipelined();
      logic [DW-1:0] ed [3];
      for (int i = 0; i < 3; i++) ed[i] = ref_mem[32 + i];
      for (int c = 0; c < RL + 4; c++) begin
         next_cycle();
         if (c < 3) set_m0(1'b1, '0, 32'h20 + c, '0);
         else       set_m0(1'b0, '0, '0, '0);
         sample();
         if (c < 3) begin
            n_cmp++;
            if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL pipe_gnt[%0d]: got %b required 1", c, m0_gnt); end
         end
         n_cmp++;
         if (c >= RL && c < RL + 3) begin
            if (m0_rvalid !== 1'b1 || m0_rdata !== ed[c-RL]) begin
               n_err++; $display("FAIL pipe_data[%0d]: got rvalid=%b rdata=%h required 1 %h", c - RL, m0_rvalid, m0_rdata, ed[c-RL]);
            end
         end else if (m0_rvalid !== 1'b0) begin
            n_err++; $display("FAIL pipe_rvalid_idle[%0d]: got %b required 0", c, m0_rvalid);
         end
      end
   endtask

   task automatic test_write_no_return();
      logic [DW-1:0] wd;
      wd = $urandom;
      next_cycle();
      set_m0(1'b1, 4'hF, 32'h5, wd);
      sample();
      n_cmp++;
      if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL wnr_gnt: got %b required 1", m0_gnt); end
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         set_m0(1'b0, '0, '0, '0);
         sample();
         n_cmp++;
         if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            n_err++; $display("FAIL wnr_rvalid[%0d]: got %b%b required 00", c, m0_rvalid, m1_rvalid);
         end
      end
      next_cycle();
      set_m0(1'b1, '0, 32'h5, '0);
      sample();
      for (int c = 1; c <= RL; c++) begin
         next_cycle();
         set_m0(1'b0, '0, '0, '0);
         sample();
      end
      n_cmp++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== wd) begin
         n_err++; $display("FAIL wnr_readback: got rvalid=%b rdata=%h required 1 %h", m0_rvalid, m0_rdata, wd);
      end
      idle(1);
   endtask

   task automatic test_raw_cross_port();
      logic [DW-1:0] wd, expd;
      wd   = $urandom;
      expd = ref_mem[64];
      expd[7:0]   = wd[7:0];
      expd[23:16] = wd[23:16];
      next_cycle();
      set_m0(1'b1, 4'b0101, 32'h40, wd);
      sample();
      next_cycle();
      set_m0(1'b0, '0, '0, '0);
      set_m1(1'b1, '0, 32'h40, '0);
      sample();
      n_cmp++;
      if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL raw_gnt: got %b required 1", m1_gnt); end
      for (int c = 1; c <= RL; c++) begin
         next_cycle();
         set_m1(1'b0, '0, '0, '0);
         sample();
      end
      n_cmp++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== expd) begin
         n_err++; $display("FAIL raw_data: got rvalid=%b rdata=%h required 1 %h", m1_rvalid, m1_rdata, expd);
      end
      idle(1);
   endtask

   task automatic test_reset_mid_read();
      next_cycle();
      set_m0(1'b1, '0, 32'h7, '0);
      sample();
      n_cmp++;
      if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL rmr_gnt: got %b required 1", m0_gnt); end
      for (int c = 0; c < RL + 3; c++) begin
         next_cycle();
         set_m0(1'b0, '0, '0, '0);
         RSTN = (c >= 2);
         sample();
         n_cmp++;
         if (m0_rvalid !== 1'b0) begin n_err++; $display("FAIL rmr_dropped[%0d]: got rvalid=%b required 0", c, m0_rvalid); end
      end
      next_cycle();
      set_m0(1'b1, '0, 32'h7, '0);
      sample();
      for (int c = 1; c <= RL; c++) begin
         next_cycle();
         set_m0(1'b0, '0, '0, '0);
         sample();
      end
      n_cmp++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== ref_mem[7]) begin
         n_err++; $display("FAIL rmr_after: got rvalid=%b rdata=%h required 1 %h", m0_rvalid, m0_rdata, ref_mem[7]);
      end
      idle(1);
   endtask

   task automatic test_withdrawn();
      next_cycle();
      set_m1(1'b1, '0, 32'h31, '0);
      sample();
      next_cycle();
      set_m0(1'b1, '0, 32'h30, '0);
      set_m1(1'b1, '0, 32'h3FF, '0);
      sample();
      n_cmp++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || bram_addr !== 32'h30) begin
         n_err++; $display("FAIL wd_contend: got gnt=%b%b addr=%h required gnt=10 addr=30", m0_gnt, m1_gnt, bram_addr);
      end
      next_cycle();
      set_m0(1'b0, '0, '0, '0);
      set_m1(1'b0, '0, 32'h3FF, '0);
      sample();
      n_cmp++;
      if (m1_gnt !== 1'b0 || bram_en !== 1'b0) begin
         n_err++; $display("FAIL wd_withdrawn: got gnt1=%b en=%b required 0 0", m1_gnt, bram_en);
      end
      idle(RL + 1);
   endtask

   task automatic test_random();
      logic g0, g1;
      g0 = 1'b0; g1 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         next_cycle();
         if (!m0_req || g0)
            set_m0($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                   32'($urandom_range(0, 63)), $urandom);
         else if ($urandom_range(0, 15) == 0)
            m0_req = 1'b0;
         if (!m1_req || g1)
            set_m1($urandom_range(0, 2) != 0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                   32'($urandom_range(0, 63)), $urandom);
         else if ($urandom_range(0, 15) == 0)
            m1_req = 1'b0;
         sample();
         n_cmp++;
         if ((m0_req || m1_req) ? (m0_gnt + m1_gnt != 1) : (m0_gnt || m1_gnt)) begin
            n_err++; $display("FAIL rand_one_grant @%0d: req=%b%b gnt=%b%b", cyc, m0_req, m1_req, m0_gnt, m1_gnt);
         end
         g0 = m0_gnt;
         g1 = m1_gnt;
      end
      idle(RL + 2);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL rand_drain: got %0d reads outstanding required 0", exp_q.size());
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write_then_read();
      test_contention();
      test_pipelined();
      test_write_no_return();
      test_raw_cross_port();
      test_reset_mid_read();
      test_withdrawn();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
